// File: rtl/key_debounce.sv
// Two-key push-button debouncer: 2-flop sync, per-key debounce FSM, press/release/long-press events.
// Optional auto-repeat after long press is compiled in when KEY_REPEAT_EN is defined.

module key_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_ev,
  output logic rpt
);

  // Degenerate timing values would break the counter compare points below.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("key_debounce: unsupported timing parameters");
  end

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [31:0]      LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0]      LONG_DONE = 32'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hold_q, hold_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             key_low;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rpt_q, rpt_d;
`endif

  always_comb begin
    sync_d  = {sync_q[0], key_n};
    key_low = ~sync_q[1];
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = rep_q;
    rpt_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // The sample that leaves IDLE is the first of the stable run.
        if (key_low) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!key_low) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          hold_d  = '0;
          press_d = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HELD: begin
        if (!key_low) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
          if (hold_q != '1) begin
            hold_d = hold_q + 32'd1;
          end
          if (hold_q == LONG_LAST) begin
            long_d = 1'b1;
          end
`ifdef KEY_REPEAT_EN
          // Repeat phase only advances once the long-press event is behind us.
          if (hold_q >= LONG_DONE) begin
            if (rep_q == REP_LAST) begin
              rep_d = '0;
              rpt_d = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
`endif
        end
      end

      RELEASE_WAIT: begin
        // A bounce back to HELD keeps the hold timer and repeat phase frozen, not reset.
        if (key_low) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      rpt_q <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

  assign level   = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign press   = press_q;
  assign rel     = rel_q;
  assign long_ev = long_q;

endmodule

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key0,
  input  logic       key1,
  output logic [1:0] key_level,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [1:0] key_long,
  output logic [1:0] key_repeat
);

  logic [1:0] key_n;

  assign key_n = {key1, key0};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (key_n[i]),
      .level  (key_level[i]),
      .press  (key_press[i]),
      .rel    (key_release[i]),
      .long_ev(key_long[i]),
      .rpt    (key_repeat[i])
    );
  end

endmodule
